// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter with frame-latched configuration.
// Define UART_TX_PARITY_EN to build the parity bit state and parity generation.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        Reset,
  input  logic [DIV_WIDTH-1:0]        BaudDiv,
  input  logic [1:0]                  DataLength,
  input  logic [1:0]                  ParityType,
  input  logic                        StopBits,
  input  logic [7:0]                  DataIn,
  input  logic                        DataValid,
  output logic                        DataReady,
  output logic                        DataOut,
  output logic                        ActiveFlag,
  output logic                        DoneFlag,
  output logic [$clog2(FIFO_DEPTH):0] FifoCount
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic [7:0]      head;

  // Transmitter state
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_in_eff;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [2:0]           last_idx;
  logic [7:0]           shift_q, shift_d;
  logic [1:0]           len_q, len_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 bit_end;
  logic                 go_parity;
  logic                 line_q, line_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  // Full status comes from the registered count only, so a pop cannot free a slot early.
  assign DataReady  = (count_q != CntW'(FIFO_DEPTH));
  assign push       = DataValid & DataReady;
  assign head       = mem_q[rd_ptr_q];
  assign FifoCount  = count_q;
  assign DataOut    = line_q;
  assign ActiveFlag = active_q;
  assign DoneFlag   = done_q;

  assign div_in_eff = (BaudDiv == '0) ? DIV_WIDTH'(1) : BaudDiv;
  assign bit_end    = (cnt_q == '0);
  assign last_idx   = 3'(len_q) + 3'd4;

`ifdef UART_TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
  logic [7:0] len_mask;

  always_comb begin
    case (DataLength)
      2'b00:   len_mask = 8'h1f;
      2'b01:   len_mask = 8'h3f;
      2'b10:   len_mask = 8'h7f;
      default: len_mask = 8'hff;
    endcase
  end

  assign go_parity = par_en_q;
`else
  logic unused_parity_type;
  assign unused_parity_type = ^ParityType;
  assign go_parity          = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state: bit sequencing, FIFO pop and per-frame configuration latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    len_d      = len_q;
    stop2_d    = stop2_q;
    div_d      = div_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    if (state_q != StIdle) cnt_d = bit_end ? (div_q - DIV_WIDTH'(1)) : (cnt_q - DIV_WIDTH'(1));

    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == last_idx) begin
            state_d    = go_parity ? StParity : StStop;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (count_q != '0) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      cnt_d   = div_in_eff - DIV_WIDTH'(1);
      div_d   = div_in_eff;
      shift_d = head;
      len_d   = DataLength;
      stop2_d = StopBits;
`ifdef UART_TX_PARITY_EN
      par_en_d  = (ParityType == 2'b01) || (ParityType == 2'b10);
      par_bit_d = (^(head & len_mask)) ^ (ParityType == 2'b01);
`endif
    end
  end

  // Outputs are computed from next-state values and registered.
  always_comb begin
    case (state_d)
      StStart:  line_d = 1'b0;
      StData:   line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: line_d = par_bit_d;
`endif
      default:  line_d = 1'b1;
    endcase
    active_d = (state_d != StIdle);
    done_d   = (state_d == StStop) && (cnt_d == '0) && (!stop2_q || stop_idx_d);
  end

  always_ff @(posedge clock) begin
    if (push && !Reset) mem_q[wr_ptr_q] <= DataIn;
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= DIV_WIDTH'(1);
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      len_q      <= '0;
      stop2_q    <= 1'b0;
      line_q     <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      stop2_q    <= stop2_d;
      line_q     <= line_d;
      active_q   <= active_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frames are predicted bit-by-bit from the frame format rules
// and compared cycle by cycle; FIFO fill and reset behaviour are checked directly.
module tb_uart_tx_fifo;

  localparam int unsigned Depth = 8;
  localparam int unsigned DivW  = 16;

`ifdef UART_TX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            Reset;
  logic [DivW-1:0] BaudDiv;
  logic [1:0]      DataLength;
  logic [1:0]      ParityType;
  logic            StopBits;
  logic [7:0]      DataIn;
  logic            DataValid;
  logic            DataReady;
  logic            DataOut;
  logic            ActiveFlag;
  logic            DoneFlag;
  logic [3:0]      FifoCount;

  uart_tx_fifo #(
    .FIFO_DEPTH (Depth),
    .DIV_WIDTH  (DivW)
  ) dut (
    .clock      (clock),
    .Reset      (Reset),
    .BaudDiv    (BaudDiv),
    .DataLength (DataLength),
    .ParityType (ParityType),
    .StopBits   (StopBits),
    .DataIn     (DataIn),
    .DataValid  (DataValid),
    .DataReady  (DataReady),
    .DataOut    (DataOut),
    .ActiveFlag (ActiveFlag),
    .DoneFlag   (DoneFlag),
    .FifoCount  (FifoCount)
  );

  always #5 clock = ~clock;

  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_line[$];
  logic exp_done[$];
  int   mcnt;
  bit   ready_m, pop_m, popped;
  int   r_len, r_par, r_st, r_div, r_len2, r_par2, r_st2, r_div2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input int div, input int len, input int par, input int st);
    BaudDiv    = DivW'(div);
    DataLength = 2'(len);
    ParityType = 2'(par);
    StopBits   = 1'(st);
  endtask

  // Reference frame: start, n data bits LSB first, optional parity, 1 or 2 stops.
  task automatic append_frame(input logic [7:0] b, input int len, input int par,
                              input int st, input int div);
    int   n, d, ones;
    logic bits[$];
    logic p;
    n    = len + 5;
    d    = (div == 0) ? 1 : div;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (ParEn && (par == 1 || par == 2)) begin
      p = ones[0] ^ (par == 1);
      bits.push_back(p);
    end
    bits.push_back(1'b1);
    if (st != 0) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++) begin
      for (int j = 0; j < d; j++) begin
        exp_line.push_back(bits[k]);
        exp_done.push_back((k == bits.size() - 1) && (j == d - 1));
      end
    end
  endtask

  // The current sample must already be the first cycle of the expected stream.
  task automatic run_expect(input string tag);
    int total;
    total = exp_line.size();
    for (int i = 0; i < total; i++) begin
      check({tag, "_line"}, 32'(DataOut), 32'(exp_line[i]));
      check({tag, "_active"}, 32'(ActiveFlag), 32'd1);
      check({tag, "_done"}, 32'(DoneFlag), 32'(exp_done[i]));
      tick();
    end
    exp_line.delete();
    exp_done.delete();
    check({tag, "_idle_line"}, 32'(DataOut), 32'd1);
    check({tag, "_idle_active"}, 32'(ActiveFlag), 32'd0);
    check({tag, "_idle_done"}, 32'(DoneFlag), 32'd0);
    check({tag, "_idle_count"}, 32'(FifoCount), 32'd0);
  endtask

  task automatic single_frame(input string tag, input logic [7:0] b, input int len,
                              input int par, input int st, input int div);
    set_cfg(div, len, par, st);
    DataIn    = b;
    DataValid = 1'b1;
    tick();
    DataValid = 1'b0;
    check({tag, "_count_push"}, 32'(FifoCount), 32'd1);
    tick();
    check({tag, "_count_pop"}, 32'(FifoCount), 32'd0);
    append_frame(b, len, par, st, div);
    run_expect(tag);
  endtask

  // Two queued bytes; configuration changes after the first pop and applies to frame two only.
  task automatic frame_pair(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                            input int div1, input int len1, input int par1, input int st1,
                            input int div2, input int len2, input int par2, input int st2);
    set_cfg(div1, len1, par1, st1);
    DataIn    = b1;
    DataValid = 1'b1;
    tick();
    DataIn = b2;
    tick();
    DataValid = 1'b0;
    set_cfg(div2, len2, par2, st2);
    check({tag, "_count"}, 32'(FifoCount), 32'd1);
    append_frame(b1, len1, par1, st1, div1);
    append_frame(b2, len2, par2, st2, div2);
    run_expect(tag);
  endtask

  initial begin
    Reset     = 1'b1;
    DataValid = 1'b1;
    DataIn    = 8'h3c;
    set_cfg(4, 3, 0, 0);
    tick();
    tick();
    check("rst_line", 32'(DataOut), 32'd1);
    check("rst_active", 32'(ActiveFlag), 32'd0);
    check("rst_done", 32'(DoneFlag), 32'd0);
    check("rst_count", 32'(FifoCount), 32'd0);
    check("rst_ready", 32'(DataReady), 32'd1);
    Reset     = 1'b0;
    DataValid = 1'b0;
    tick();
    check("post_rst_line", 32'(DataOut), 32'd1);

    single_frame("a5_8n1_d4", 8'ha5, 3, 0, 0, 4);
    single_frame("35_7e2_d3", 8'h35, 2, 2, 1, 3);
    single_frame("5a_8n1_d0", 8'h5a, 3, 0, 0, 0);
    single_frame("c3_8n1_d1", 8'hc3, 3, 0, 0, 1);
    single_frame("1e_5o1_d2", 8'h1e, 0, 1, 0, 2);
    frame_pair("b2b_8n1_d2", 8'h96, 8'h0f, 2, 3, 0, 0, 2, 3, 0, 0);
    frame_pair("cfg_change", 8'h71, 8'hee, 3, 3, 0, 0, 1, 1, 2, 1);

    for (int t = 0; t < 16; t++) begin
      r_len = int'($urandom_range(0, 3));
      r_par = int'($urandom_range(0, 3));
      r_st  = int'($urandom_range(0, 1));
      r_div = int'($urandom_range(0, 4));
      single_frame("rand_single", 8'($urandom_range(0, 255)), r_len, r_par, r_st, r_div);
    end
    for (int t = 0; t < 6; t++) begin
      r_len  = int'($urandom_range(0, 3));
      r_par  = int'($urandom_range(0, 3));
      r_st   = int'($urandom_range(0, 1));
      r_div  = int'($urandom_range(1, 3));
      r_len2 = int'($urandom_range(0, 3));
      r_par2 = int'($urandom_range(0, 3));
      r_st2  = int'($urandom_range(0, 1));
      r_div2 = int'($urandom_range(0, 3));
      frame_pair("rand_pair", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 r_div, r_len, r_par, r_st, r_div2, r_len2, r_par2, r_st2);
    end

    // Fill: slow baud so only the first entry leaves during the burst.
    set_cfg(1000, 3, 0, 0);
    mcnt      = 0;
    popped    = 1'b0;
    DataValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ready_m = (mcnt != int'(Depth));
      check("fill_ready", 32'(DataReady), 32'(ready_m));
      DataIn = 8'(c + 8'h40);
      tick();
      pop_m  = !popped && (mcnt > 0);
      popped = popped | pop_m;
      mcnt   = mcnt + int'(ready_m) - int'(pop_m);
      check("fill_count", 32'(FifoCount), 32'(mcnt));
    end
    check("full_count", 32'(FifoCount), 32'd8);
    check("full_ready", 32'(DataReady), 32'd0);
    check("full_line", 32'(DataOut), 32'd0);
    check("full_active", 32'(ActiveFlag), 32'd1);
    Reset = 1'b1;
    tick();
    check("rst_push_count", 32'(FifoCount), 32'd0);
    check("rst_push_ready", 32'(DataReady), 32'd1);
    check("rst_push_line", 32'(DataOut), 32'd1);
    Reset     = 1'b0;
    DataValid = 1'b0;
    tick();
    check("rst_push_count2", 32'(FifoCount), 32'd0);

    // Reset mid-DATA with bytes queued: frame aborted, queue discarded.
    set_cfg(4, 3, 0, 0);
    DataValid = 1'b1;
    DataIn    = 8'h11;
    tick();
    DataIn = 8'h22;
    tick();
    DataIn = 8'h33;
    tick();
    DataValid = 1'b0;
    check("abort_queued", 32'(FifoCount), 32'd2);
    for (int c = 0; c < 8; c++) tick();
    check("abort_pre_active", 32'(ActiveFlag), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_line", 32'(DataOut), 32'd1);
    check("abort_active", 32'(ActiveFlag), 32'd0);
    check("abort_count", 32'(FifoCount), 32'd0);
    check("abort_done", 32'(DoneFlag), 32'd0);
    for (int c = 0; c < 60; c++) begin
      tick();
      check("abort_quiet_line", 32'(DataOut), 32'd1);
      check("abort_quiet_active", 32'(ActiveFlag), 32'd0);
    end

    single_frame("after_abort", 8'h81, 3, 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
